// File: rtl/uint_to_oh_stream_if.sv
// Handshake bundle for the index-to-one-hot decoder: index in, one-hot out,
// plus the error-count side channel.
interface uint_to_oh_stream_if #(
  parameter int N     = 4,
  parameter int ERR_W = 8
);
  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

  logic             io_in_valid;
  logic             io_in_ready;
  logic [IDX_W-1:0] io_in_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [N-1:0]     io_out_bits;
  logic             io_out_err;
  logic [ERR_W-1:0] io_err_count;
  logic             io_clear_err;

  modport master (
    output io_in_valid, io_in_bits, io_out_ready, io_clear_err,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_err, io_err_count
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready, io_clear_err,
    output io_in_ready, io_out_valid, io_out_bits, io_out_err, io_err_count
  );
endinterface

// File: rtl/uint_to_oh_stream.sv
// Binary index to one-hot decoder behind a 2-entry FIFO. Decode happens at
// enqueue so outputs come straight from the head register.
module uint_to_oh_stream #(
  parameter int N     = 4,
  parameter int ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uint_to_oh_stream_if.slave    io
);
  typedef logic [N:0] entry_t;  // {err, onehot}

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           entry_in;
  logic [1:0]       count_q, count_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             push, pop;

  always_comb begin
    entry_in = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(io.io_in_bits) == i) entry_in[i] = 1'b1;
    end
    entry_in[N] = ~|entry_in[N-1:0];
  end

  assign io.io_in_ready  = (count_q != 2'd2);
  assign io.io_out_valid = (count_q != 2'd0);
  assign io.io_out_bits  = io.io_out_valid ? head_q[N-1:0] : '0;
  assign io.io_out_err   = io.io_out_valid & head_q[N];
  assign io.io_err_count = err_cnt_q;

  assign push = io.io_in_valid & io.io_in_ready;
  assign pop  = io.io_out_valid & io.io_out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = entry_in;
        else                 tail_d = entry_in;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // simultaneous push/pop only happens at count 1: new entry replaces head
      2'b11:   head_d = entry_in;
      default: ;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (io.io_clear_err) begin
      err_cnt_d = '0;
    end else if (push && entry_in[N] && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_uint_to_oh_stream.sv
// Bench for uint_to_oh_stream: directed cases on N=4 and N=5/ERR_W=2 instances,
// then random traffic on the N=5 instance against a queue model.
module tb_uint_to_oh_stream;
  localparam int NB = 5;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  uint_to_oh_stream_if #(.N(4),  .ERR_W(8)) ifa ();
  uint_to_oh_stream_if #(.N(NB), .ERR_W(2)) ifb ();

  uint_to_oh_stream #(.N(4),  .ERR_W(8)) dut_a (.clk(clk), .reset_n(reset_n), .io(ifa));
  uint_to_oh_stream #(.N(NB), .ERR_W(2)) dut_b (.clk(clk), .reset_n(reset_n), .io(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB:0] ref_entry(input int idx);
    if (idx < NB) return {1'b0, NB'(1 << idx)};
    return {1'b1, {NB{1'b0}}};
  endfunction

  logic [NB:0] mq[$];
  logic [NB:0] exp_e;
  int          merr;
  bit          m_push, m_pop;

  initial begin
    reset_n = 1'b0;
    ifa.io_in_valid = 0; ifa.io_in_bits = '0; ifa.io_out_ready = 0; ifa.io_clear_err = 0;
    ifb.io_in_valid = 0; ifb.io_in_bits = '0; ifb.io_out_ready = 0; ifb.io_clear_err = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    check("rst_out_valid", ifa.io_out_valid, 0);
    check("rst_out_bits",  ifa.io_out_bits, 0);
    check("rst_out_err",   ifa.io_out_err, 0);
    check("rst_err_count", ifa.io_err_count, 0);
    check("rst_in_ready",  ifa.io_in_ready, 1);
    check("rst_b_ready",   ifb.io_in_ready, 1);

    // single push, one cycle latency
    ifa.io_in_valid = 1; ifa.io_in_bits = 2'd2; ifa.io_out_ready = 1;
    tick();
    ifa.io_in_valid = 0;
    check("t1_valid", ifa.io_out_valid, 1);
    check("t1_bits",  ifa.io_out_bits, 4'b0100);
    check("t1_err",   ifa.io_out_err, 0);
    tick();
    check("t1_valid_after", ifa.io_out_valid, 0);
    check("t1_bits_after",  ifa.io_out_bits, 0);

    // back-pressure: fill, hold third, then drain in order
    ifa.io_out_ready = 0; ifa.io_in_valid = 1; ifa.io_in_bits = 2'd0;
    tick();
    check("t2_bits0",  ifa.io_out_bits, 4'b0001);
    check("t2_ready1", ifa.io_in_ready, 1);
    ifa.io_in_bits = 2'd1;
    tick();
    check("t2_ready_full", ifa.io_in_ready, 0);
    check("t2_bits_hold",  ifa.io_out_bits, 4'b0001);
    ifa.io_in_bits = 2'd3;
    tick();
    check("t2_ready_still", ifa.io_in_ready, 0);
    check("t2_bits_stable", ifa.io_out_bits, 4'b0001);
    ifa.io_out_ready = 1;
    tick();
    check("t2_bits1",     ifa.io_out_bits, 4'b0010);
    check("t2_ready_ret", ifa.io_in_ready, 1);
    tick();
    ifa.io_in_valid = 0;
    check("t2_bits3", ifa.io_out_bits, 4'b1000);
    tick();
    check("t2_drained", ifa.io_out_valid, 0);

    // streaming at full rate
    ifa.io_in_valid = 1; ifa.io_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      ifa.io_in_bits = 2'(i % 4);
      tick();
      check("t5_in_ready", ifa.io_in_ready, 1);
      check("t5_valid",    ifa.io_out_valid, 1);
      check("t5_bits",     ifa.io_out_bits, 32'(1 << (i % 4)));
    end
    ifa.io_in_valid = 0;
    tick();
    check("t5_end_valid", ifa.io_out_valid, 0);

    // out-of-range on N=5
    ifb.io_in_valid = 1; ifb.io_in_bits = 3'd6; ifb.io_out_ready = 1;
    tick();
    check("t3_bits_oor",  ifb.io_out_bits, 0);
    check("t3_err_oor",   ifb.io_out_err, 1);
    check("t3_cnt_oor",   ifb.io_err_count, 1);
    ifb.io_in_bits = 3'd4;
    tick();
    check("t3_bits4", ifb.io_out_bits, 5'b10000);
    check("t3_err4",  ifb.io_out_err, 0);
    check("t3_cnt4",  ifb.io_err_count, 1);
    ifb.io_in_valid = 0;
    tick();

    // saturation and clear priority with ERR_W=2
    ifb.io_clear_err = 1;
    tick();
    ifb.io_clear_err = 0;
    check("t4_cleared", ifb.io_err_count, 0);
    ifb.io_in_valid = 1; ifb.io_in_bits = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_sat", ifb.io_err_count, (i < 3) ? i + 1 : 3);
    end
    ifb.io_clear_err = 1;
    tick();
    check("t4_clear_prio", ifb.io_err_count, 0);
    ifb.io_clear_err = 0; ifb.io_in_valid = 0;
    tick(); tick();
    check("t4_drained", ifb.io_out_valid, 0);

    // random traffic against the queue model
    mq.delete();
    merr = 0;
    for (int c = 0; c < 300; c++) begin
      ifb.io_in_valid  = 1'($urandom_range(0, 1));
      ifb.io_in_bits   = 3'($urandom_range(0, 7));
      ifb.io_out_ready = ($urandom_range(0, 3) != 0);
      ifb.io_clear_err = ($urandom_range(0, 15) == 0);
      exp_e = (mq.size() != 0) ? mq[0] : '0;
      check("rnd_in_ready",  ifb.io_in_ready, mq.size() != 2);
      check("rnd_out_valid", ifb.io_out_valid, mq.size() != 0);
      check("rnd_out_bits",  ifb.io_out_bits, exp_e[NB-1:0]);
      check("rnd_out_err",   ifb.io_out_err, exp_e[NB]);
      check("rnd_err_count", ifb.io_err_count, merr);
      m_push = ifb.io_in_valid && (mq.size() < 2);
      m_pop  = ifb.io_out_ready && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(ref_entry(int'(ifb.io_in_bits)));
      if (ifb.io_clear_err) merr = 0;
      else if (m_push && int'(ifb.io_in_bits) >= NB && merr < 3) merr++;
      tick();
    end
    ifb.io_in_valid = 0; ifb.io_clear_err = 0; ifb.io_out_ready = 1;
    tick(); tick();

    // async reset with both FIFOs full
    ifa.io_out_ready = 0; ifa.io_in_valid = 1; ifa.io_in_bits = 2'd1;
    ifb.io_out_ready = 0; ifb.io_in_valid = 1; ifb.io_in_bits = 3'd7;
    tick();
    ifa.io_in_bits = 2'd2;
    tick();
    ifa.io_in_valid = 0; ifb.io_in_valid = 0;
    check("t6_full",    ifa.io_in_ready, 0);
    check("t6_b_errs",  ifb.io_err_count != 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", ifa.io_out_valid, 0);
    check("t6_rst_bits",  ifa.io_out_bits, 0);
    check("t6_rst_ready", ifa.io_in_ready, 1);
    check("t6_rst_cnt",   ifb.io_err_count, 0);
    check("t6_rst_b_val", ifb.io_out_valid, 0);
    #3;
    reset_n = 1'b1;
    ifa.io_out_ready = 1; ifb.io_out_ready = 1;
    tick();
    check("t6_no_stale_a", ifa.io_out_valid, 0);
    check("t6_no_stale_b", ifb.io_out_valid, 0);
    ifa.io_in_valid = 1; ifa.io_in_bits = 2'd3;
    tick();
    ifa.io_in_valid = 0;
    check("t6_fresh_bits", ifa.io_out_bits, 4'b1000);
    tick();
    check("t6_fresh_done", ifa.io_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
